// File: rtl/lsu_pkg.sv
// lsu_pkg: mem_op width/sign codes shared with the decoder, LSU state encoding
package lsu_pkg;
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

    function automatic logic op_illegal(input logic [2:0] op, input logic [1:0] lo);
        return !(op inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU}) ||
               ((op == MEM_H || op == MEM_HU) && lo[0]) ||
               (op == MEM_W && lo != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store strobe/lane replication and load lane extract with sign/zero extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);
    logic [31:0] sh;
    always_comb begin
        sh        = word >> {lo, 3'b000};
        // op[1:0] selects size: 00 byte, 01 half, 10 word
        wstrb     = op[1:0] == 2'b00 ? 4'b0001 << lo :
                    op[1:0] == 2'b01 ? 4'b0011 << lo : 4'b1111;
        wdata_rep = op[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                    op[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        load_data = op == MEM_B  ? {{24{sh[7]}}, sh[7:0]} :
                    op == MEM_H  ? {{16{sh[15]}}, sh[15:0]} :
                    op == MEM_BU ? {24'b0, sh[7:0]} :
                    op == MEM_HU ? {16'b0, sh[15:0]} : word;
    end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between EXU and WBU
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wen,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              resp_valid,
    output logic              resp_ready,
    input  logic [DATA_W-1:0] resp_rdata,
    input  logic              resp_err
);
    lsu_state_e        state, state_nxt;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, wdata_rep, load_data;
    logic [3:0]        strb;
    logic              wen_q, accept, noop, bad;

    assign accept = in_valid && in_ready;
    assign noop   = !mem_rd_en && !mem_wr_en;
    // mem_op is only meaningful when an access is actually requested
    assign bad    = !noop && ((mem_rd_en && mem_wr_en) || op_illegal(mem_op, addr[1:0]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (accept ? (bad || noop ? DONE : REQ) : IDLE) :
                    state == REQ  ? (req_ready ? WAIT : REQ) :
                    state == WAIT ? (resp_valid ? DONE : WAIT) :
                                    (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready   = state == IDLE;
        req_valid  = state == REQ;
        resp_ready = state == WAIT;
        out_valid  = state == DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            op_q    <= mem_op;
            addr_q  <= addr;
            wdata_q <= wdata;
            wen_q   <= mem_wr_en;
            rdata   <= '0;
            err     <= bad;
        end else if (resp_ready && resp_valid) begin
            rdata   <= resp_err || wen_q ? '0 : load_data;
            err     <= resp_err;
        end
    end

    lsu_align u_align (
        .op        (op_q),
        .lo        (addr_q[1:0]),
        .wdata     (wdata_q),
        .word      (resp_rdata),
        .wstrb     (strb),
        .wdata_rep (wdata_rep),
        .load_data (load_data)
    );

    assign req_wen   = wen_q;
    assign req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign req_wdata = wdata_rep;
    assign req_wstrb = wen_q ? strb : 4'b0000;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed LSU bench; expectations queued at issue, checked by an output monitor
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0, rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic        mem_rd_en = 1'b0, mem_wr_en = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] addr = '0, wdata = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] rdata;
    logic        err;
    logic        req_valid, req_ready = 1'b0, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid = 1'b0, resp_ready;
    logic [31:0] resp_rdata = '0;
    logic        resp_err = 1'b0;

    typedef struct {logic [31:0] rdata; logic err;} exp_t;
    exp_t exp_q[$];
    int checks = 0, failures = 0;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .out_valid(out_valid), .out_ready(out_ready),
        .rdata(rdata), .err(err), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: sampled on the falling edge, i.e. the values the DUT sees at the next rising edge
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h/%b expected=none", rdata, err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", rdata, e.rdata);
                chk1("err", err, e.err);
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int rq_dly, input int rs_dly, input int or_dly,
                          input logic [31:0] word, input logic rerr, input logic bus,
                          input logic [3:0] x_strb, input logic [31:0] x_wdata,
                          input logic [31:0] x_rdata, input logic x_err, input int x_lat);
        int lat, rqc, rsc, rq_hs, rs_hs;
        exp_q.push_back('{x_rdata, x_err});
        chk1("in_ready_idle", in_ready, 1'b1);
        mem_rd_en = rd; mem_wr_en = wr; mem_op = op; addr = a; wdata = wd;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 1; rqc = 0; rsc = 0; rq_hs = 0; rs_hs = 0;
        while (!out_valid && lat < 100) begin
            req_ready = 1'b0; resp_valid = 1'b0;
            if (req_valid) begin
                chk("req_addr", req_addr, a & 32'hFFFF_FFFC);
                chk1("req_wen", req_wen, wr);
                chk("req_wstrb", {28'b0, req_wstrb}, {28'b0, x_strb});
                if (wr) chk("req_wdata", req_wdata, x_wdata);
                if (rqc == rq_dly) begin req_ready = 1'b1; rq_hs++; end
                else rqc++;
            end
            if (resp_ready) begin
                if (rsc == rs_dly) begin
                    resp_valid = 1'b1; resp_rdata = word; resp_err = rerr; rs_hs++;
                end else rsc++;
            end
            tick;
            lat++;
        end
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0; resp_err = 1'b0;
        chk("latency", 32'(lat), 32'(x_lat));
        chk1("out_valid", out_valid, 1'b1);
        chk("req_handshakes", 32'(rq_hs), {31'b0, bus});
        chk("resp_handshakes", 32'(rs_hs), {31'b0, bus});
        for (int i = 0; i < or_dly; i++) begin
            chk1("hold_out_valid", out_valid, 1'b1);
            chk("hold_rdata", rdata, x_rdata);
            chk1("hold_err", err, x_err);
            chk1("hold_in_ready", in_ready, 1'b0);
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk1("back_to_idle", in_ready, 1'b1);
        chk1("out_valid_drop", out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_resp_ready", resp_ready, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b1;
        tick;
        // rd wr op addr wdata rq rs or word rerr bus strb xwdata xrdata xerr lat
        access(0, 1, MEM_B,  32'h8000_0003, 32'h0000_00AB, 0, 0, 0, 32'h0, 0, 1, 4'b1000, 32'hABAB_ABAB, 32'h0, 0, 3);
        access(1, 0, MEM_B,  32'h8000_0002, 32'h0, 0, 0, 0, 32'h1280_3344, 0, 1, 4'b0000, 32'h0, 32'hFFFF_FF80, 0, 3);
        access(1, 0, MEM_BU, 32'h8000_0002, 32'h0, 0, 0, 0, 32'h1280_3344, 0, 1, 4'b0000, 32'h0, 32'h0000_0080, 0, 3);
        access(1, 0, MEM_H,  32'h8000_0001, 32'h0, 0, 0, 0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1, 1);
        access(1, 0, MEM_W,  32'h8000_0010, 32'h0, 4, 3, 0, 32'hDEAD_BEEF, 0, 1, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 10);
        access(1, 0, MEM_HU, 32'h8000_0002, 32'h0, 0, 0, 5, 32'hCAFE_1234, 0, 1, 4'b0000, 32'h0, 32'h0000_CAFE, 0, 3);
        access(1, 0, MEM_H,  32'h8000_0002, 32'h0, 0, 0, 0, 32'hCAFE_1234, 0, 1, 4'b0000, 32'h0, 32'hFFFF_CAFE, 0, 3);
        access(1, 0, MEM_W,  32'h8000_0008, 32'h0, 0, 0, 5, 32'h5555_5555, 1, 1, 4'b0000, 32'h0, 32'h0, 1, 3);
        access(0, 1, MEM_H,  32'h8000_0002, 32'h1234_BEEF, 0, 0, 0, 32'h0, 0, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 3);
        access(0, 1, MEM_W,  32'h8000_0004, 32'h0123_4567, 0, 0, 0, 32'h0, 0, 1, 4'b1111, 32'h0123_4567, 32'h0, 0, 3);
        access(0, 0, MEM_W,  32'h8000_0003, 32'h0, 0, 0, 0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 0, 1);
        access(1, 1, MEM_W,  32'h8000_0000, 32'h0, 0, 0, 0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1, 1);
        access(1, 0, 3'b011, 32'h8000_0000, 32'h0, 0, 0, 0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1, 1);
        access(1, 0, MEM_W,  32'h8000_0002, 32'h0, 0, 0, 0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1, 1);
        // Abandon a load mid-WAIT with reset; no result is expected from it
        mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_op = MEM_W; addr = 32'h8000_0020;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !resp_ready; n++) begin
            req_ready = req_valid;
            tick;
        end
        req_ready = 1'b0;
        chk1("reached_wait", resp_ready, 1'b1);
        tick;
        rst = 1'b0;
        #1;
        chk1("mid_rst_in_ready", in_ready, 1'b1);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk1("mid_rst_req_valid", req_valid, 1'b0);
        chk1("mid_rst_resp_ready", resp_ready, 1'b0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk1("mid_rst_err", err, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        access(1, 0, MEM_B,  32'h8000_0001, 32'h0, 0, 0, 0, 32'h0000_7F00, 0, 1, 4'b0000, 32'h0, 32'h0000_007F, 0, 3);
        repeat (2) tick;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the NPC core: consumes the memory-control fields emitted by the instruction decoder (`mem_rd_en`, `mem_wr_en`, `mem_op`) together with the ALU-computed address and store data, and performs the access on a single-outstanding request/response memory port. It generates byte strobes and lane-aligned write data for stores, and lane-extracts and sign/zero-extends load data before handing the result to write-back. One access is in flight at a time; the block sits between EXU and WBU.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32, other values unsupported
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  EXU request valid
- `in_ready`  out  1  LSU can accept; high only in IDLE
- `mem_rd_en`, `mem_wr_en`  in  1 each  load / store select from decoder
- `mem_op`  in  3  width/sign code, equal to funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `addr`  in  ADDR_W  byte address
- `wdata`  in  DATA_W  store data, LSB-aligned
- `out_valid`  out  1  result valid to WBU
- `out_ready`  in  1  WBU accepts
- `rdata`  out  DATA_W  extended load data; 0 for stores/no-op
- `err`  out  1  misaligned, illegal mem_op, rd&wr both set, or bus error
- `req_valid`, `req_ready`  out/in  1  bus request handshake
- `req_wen`  out  1  1 = write
- `req_addr`  out  ADDR_W  word-aligned (`addr[1:0]` forced 00)
- `req_wdata`  out  DATA_W  lane-replicated store data
- `req_wstrb`  out  4  byte strobes (0 for reads)
- `resp_valid`, `resp_ready`  in/out  1  bus response handshake
- `resp_rdata`  in  DATA_W  full word read data
- `resp_err`  in  1  bus error

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE; all registered outputs 0 (`out_valid`, `req_valid`, `resp_ready`, `rdata`, `err`).
- IDLE: `in_valid && in_ready` latches all inputs. Illegal (mem_op ∉ {000,001,010,100,101}, both enables set, H misaligned `addr[0]`, W misaligned `addr[1:0]≠0`) → DONE with `err=1`, no bus transaction. Neither enable set → DONE, `err=0`, `rdata=0`. Otherwise → REQ.
- REQ: `req_valid=1`, fields stable until `req_ready`; on handshake → WAIT.
- WAIT: `resp_ready=1`; on `resp_valid` capture data/err → DONE. Responses are sampled only in WAIT.
- DONE: `out_valid=1`, `rdata`/`err` stable until `out_ready`; then → IDLE.
- Stores: B strobe `0001<<addr[1:0]`, data `{4{wdata[7:0]}}`; H strobe `0011<<addr[1:0]`, data `{2{wdata[15:0]}}`; W `1111`, `wdata`.
- Loads: word shifted right by `addr[1:0]*8`; B/H sign-extend, BU/HU zero-extend, W unchanged. On `resp_err`, `rdata=0`, `err=1`.

## Timing
- `in_ready` = (state==IDLE), combinational from state.
- Best case accept→`out_valid`: 3 cycles (REQ, WAIT, DONE each ≥1 cycle); illegal/no-op: 1 cycle.
- Throughput: one access per ≥2 cycles (DONE→IDLE); no back-to-back accept in DONE.
- `req_valid` never drops without `req_ready`; `out_valid` never drops without `out_ready`.
- Reset asserted mid-transaction: abandon immediately, return to IDLE; bus slave shares the same reset.

## Structure
- Shared package `lsu_pkg`: `mem_op` constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) reused by the decoder, state enum.
- Sub-module `lsu_align`: purely combinational strobe/lane-replication for stores and shift/extend for loads; FSM and registers stay in `lsu`.

## Test plan
- SB addr 0x8000_0003 wdata 0x0000_00AB, req_ready=1 → req_addr 0x8000_0000, wstrb 1000, req_wdata 0xABABABAB, out_valid 3 cycles after accept, rdata 0.
- LB addr 0x…02, resp 0x1280_3344 → rdata 0xFFFF_FF80; LBU same → 0x0000_0080.
- LH addr 0x…01 → err=1 in 1 cycle, req_valid never asserted.
- LW with req_ready low 4 cycles and resp_valid delayed 3 → req fields stable, rdata = resp word, single handshake each.
- out_ready low 5 cycles in DONE → out_valid/rdata held, in_ready 0; resp_err=1 case → err=1, rdata 0.
- Reset pulsed during WAIT → all outputs 0, in_ready 1, next access completes normally.
